// File: rtl/pwm_gen_if.sv
// Software-facing control/status bundle for the PWM transmitter.
// The GPIO side is the master; pwm_gen is the slave.
interface pwm_gen_if #(
  parameter int CNT_WIDTH      = 32,
  parameter int TICK_CNT_WIDTH = 16
);
  logic                      enable;
  logic [CNT_WIDTH-1:0]      period;
  logic [CNT_WIDTH-1:0]      duty;
  logic                      load;
  logic                      load_ack;
  logic                      pending;
  logic                      pwm_out;
  logic                      period_tick;
  logic [TICK_CNT_WIDTH-1:0] period_count;

  modport master (
    output enable, period, duty, load,
    input  load_ack, pending, pwm_out, period_tick, period_count
  );

  modport slave (
    input  enable, period, duty, load,
    output load_ack, pending, pwm_out, period_tick, period_count
  );
endinterface

// File: rtl/pwm_gen.sv
// Double-buffered PWM generator: loaded period/duty wait in pend registers
// and move to the active set only on a period boundary or while idle.
module pwm_gen #(
  parameter int CNT_WIDTH      = 32,
  parameter int TICK_CNT_WIDTH = 16
) (
  input  logic     sysclk,
  input  logic     sysreset_n,
  pwm_gen_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0]      ONE      = 1;
  localparam logic [TICK_CNT_WIDTH-1:0] TICK_ONE = 1;

  logic [CNT_WIDTH-1:0]      r_cnt, r_act_period, r_act_duty, r_pend_period, r_pend_duty;
  logic                      r_en, r_pending, r_ack, r_pwm, r_tick;
  logic [TICK_CNT_WIDTH-1:0] r_pcount;

  logic                 w_at_end, w_apply, w_pwm_nxt, w_tick_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt, w_per_nxt, w_duty_nxt;

  // r_en is the enable that governs the current cycle; a cycle entered with
  // enable low keeps cnt at 0, so the first enabled cycle always starts at 0.
  always_comb begin
    w_at_end   = (r_act_period != '0) && (r_cnt == r_act_period - ONE);
    w_apply    = r_pending && (!bus.enable || (r_act_period == '0) || w_at_end);
    w_per_nxt  = w_apply ? r_pend_period : r_act_period;
    w_duty_nxt = w_apply ? r_pend_duty   : r_act_duty;
    w_cnt_nxt  = r_cnt + ONE;
    if (!bus.enable || !r_en || (r_act_period == '0) || w_at_end)
      w_cnt_nxt = '0;
    w_pwm_nxt  = bus.enable && (w_per_nxt != '0) && (w_cnt_nxt < w_duty_nxt);
    w_tick_nxt = bus.enable && (w_per_nxt != '0) && (w_cnt_nxt == w_per_nxt - ONE);
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      r_cnt         <= '0;
      r_act_period  <= '0;
      r_act_duty    <= '0;
      r_pend_period <= '0;
      r_pend_duty   <= '0;
      r_en          <= 1'b0;
      r_pending     <= 1'b0;
      r_ack         <= 1'b0;
      r_pwm         <= 1'b0;
      r_tick        <= 1'b0;
      r_pcount      <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_act_period <= w_per_nxt;
      r_act_duty   <= w_duty_nxt;
      r_en         <= bus.enable;
      r_ack        <= bus.load;
      r_pwm        <= w_pwm_nxt;
      r_tick       <= w_tick_nxt;
      if (r_tick)
        r_pcount <= r_pcount + TICK_ONE;
      // A load coinciding with an apply lands in pend after the old pend moved out.
      if (bus.load) begin
        r_pend_period <= bus.period;
        r_pend_duty   <= bus.duty;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_pending     <= 1'b0;
      end
    end
  end

  assign bus.load_ack     = r_ack;
  assign bus.pending      = r_pending;
  assign bus.pwm_out      = r_pwm;
  assign bus.period_tick  = r_tick;
  assign bus.period_count = r_pcount;
endmodule

// File: tb/tb_pwm_gen.sv
// Randomised and directed bench for pwm_gen against a phase-based model.
module tb_pwm_gen;
  localparam int CW = 32;
  localparam int TW = 10;

  logic sysclk = 1'b0;
  logic sysreset_n = 1'b0;

  pwm_gen_if #(.CNT_WIDTH(CW), .TICK_CNT_WIDTH(TW)) bus();

  pwm_gen #(.CNT_WIDTH(CW), .TICK_CNT_WIDTH(TW)) dut (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .bus        (bus)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  // model: a running cycle is described by its enable, position in period and settings
  bit          m_en, m_pend, m_ack;
  int unsigned m_pos, m_P, m_D, m_pP, m_pD, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit exp_pwm();
    return m_en && (m_P != 0) && (m_pos < m_D);
  endfunction

  function automatic bit exp_tick();
    return m_en && (m_P != 0) && (m_pos == m_P - 1);
  endfunction

  task automatic model_edge(input bit rst_n, input bit en, input bit ld,
                            input int unsigned per, input int unsigned dty);
    bit boundary, apply;
    if (!rst_n) begin
      m_en = 0; m_pend = 0; m_ack = 0;
      m_pos = 0; m_P = 0; m_D = 0; m_pP = 0; m_pD = 0; m_cnt = 0;
    end else begin
      boundary = (m_P != 0) && (m_pos == m_P - 1);
      apply    = m_pend && (!en || m_P == 0 || boundary);
      if (exp_tick()) m_cnt = (m_cnt + 1) % (1 << TW);
      if (!en || !m_en || m_P == 0 || boundary) m_pos = 0;
      else m_pos = m_pos + 1;
      if (apply) begin m_P = m_pP; m_D = m_pD; m_pend = 0; end
      if (ld) begin m_pP = per; m_pD = dty; m_pend = 1; end
      m_ack = ld;
      m_en  = en;
    end
  endtask

  task automatic cyc(input bit rst_n, input bit en, input bit ld,
                     input int unsigned per, input int unsigned dty);
    sysreset_n = rst_n;
    bus.enable = en;
    bus.load   = ld;
    bus.period = per;
    bus.duty   = dty;
    @(posedge sysclk);
    model_edge(rst_n, en, ld, per, dty);
    @(negedge sysclk);
    chk("pwm_out",      32'(bus.pwm_out),      32'(exp_pwm()));
    chk("period_tick",  32'(bus.period_tick),  32'(exp_tick()));
    chk("load_ack",     32'(bus.load_ack),     32'(m_ack));
    chk("pending",      32'(bus.pending),      32'(m_pend));
    chk("period_count", 32'(bus.period_count), m_cnt);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(1, en, 0, 0, 0);
  endtask

  task automatic run_to_pos(input int unsigned p);
    for (int i = 0; i < 64 && m_pos != p; i++) cyc(1, 1, 0, 0, 0);
  endtask

  initial begin
    bus.enable = 0; bus.load = 0; bus.period = '0; bus.duty = '0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 7, 7);
    // 10/3 from reset, then switch to 4/1 mid-period
    cyc(1, 1, 1, 10, 3);
    run(25, 1);
    run_to_pos(5);
    cyc(1, 1, 1, 4, 1);
    run(20, 1);
    // duty 0, equal to period, above period
    cyc(1, 1, 1, 8, 0);  run(20, 1);
    cyc(1, 1, 1, 8, 8);  run(20, 1);
    cyc(1, 1, 1, 8, 12); run(20, 1);
    // period 1 gives a constant level and a constant tick
    cyc(1, 1, 1, 1, 1);  run(6, 1);
    cyc(1, 1, 1, 1, 0);  run(6, 1);
    // disable mid-high, load while disabled, re-enable
    cyc(1, 1, 1, 10, 3); run(12, 1);
    run_to_pos(1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 6, 2);
    run(3, 0);
    run(15, 1);
    // reset with a load in flight
    cyc(1, 1, 1, 10, 3); run(12, 1);
    run_to_pos(5);
    cyc(1, 1, 1, 9, 4);
    cyc(0, 1, 1, 5, 2);
    run(5, 1);
    // tick counter wrap with 2/1
    cyc(1, 1, 1, 2, 1);
    run(2 * (1 << TW) + 8, 1);
    // load at the same edge as a boundary
    cyc(1, 1, 1, 5, 2); run(8, 1);
    run_to_pos(4);
    cyc(1, 1, 1, 3, 1); run(12, 1);
    // random traffic
    for (int i = 0; i < 4000; i++)
      cyc(($urandom % 250) != 0, ($urandom % 20) != 0, ($urandom % 9) == 0,
          $urandom % 13, $urandom % 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
